// File: rtl/fg_burst_waveform_generator.sv
// Phase-accumulator function generator with triggered N-period burst mode and
// shadowed waveform configuration that only changes at period boundaries.
//   state   | meaning
//   IDLE    | phase/prescaler/period cleared, shadows track inputs, s=0
//   RUN     | prescaled phase accumulation, busy_o=1
module fg_burst_waveform_generator #(
    parameter int BITWIDTH         = 8,
    parameter int PHASE_BITWIDTH   = 16,
    parameter int PSC_BITWIDTH     = 9,
    parameter int BURST_BITWIDTH   = 8,
    parameter int OUT_STROBE_DELAY = 0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      enable_i,
    input  logic [1:0]                mode_i,
    input  logic                      burstMode_i,
    input  logic                      trigger_i,
    input  logic [BURST_BITWIDTH-1:0] burstCount_i,
    input  logic [PSC_BITWIDTH-1:0]   prescaler_i,
    input  logic [PHASE_BITWIDTH-1:0] phaseInc_i,
    input  logic [BITWIDTH-1:0]       duty_i,
    input  logic [BITWIDTH-1:0]       amplitude_i,
    input  logic [BITWIDTH-1:0]       offset_i,
    input  logic                      radix_i,
    output logic [BITWIDTH-1:0]       out_o,
    output logic                      outValid_STRB_o,
    output logic                      busy_o,
    output logic                      burstDone_o
);

    localparam int B = BITWIDTH;
    localparam int P = PHASE_BITWIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] MODE_CONST = 2'b00;
    localparam logic [1:0] MODE_SQUARE = 2'b01;
    localparam logic [1:0] MODE_TRI   = 2'b10;
    localparam logic [1:0] MODE_SAW   = 2'b11;

    localparam logic [B-1:0] POS_FULL = {1'b0, {(B-1){1'b1}}};
    localparam logic [B-1:0] NEG_FULL = {1'b1, {(B-2){1'b0}}, 1'b1};
    localparam logic [B-1:0] SAT_MIN  = {1'b1, {(B-1){1'b0}}};

    logic [0:0]                state;
    logic [PSC_BITWIDTH-1:0]   psc_cnt;
    logic [PSC_BITWIDTH-1:0]   psc_sh;
    logic [P-1:0]              phase;
    logic [P-1:0]              inc_sh;
    logic [1:0]                mode_sh;
    logic [B-1:0]              duty_sh;
    logic                      burst_sh;
    logic [BURST_BITWIDTH-1:0] period_cnt;
    logic [BURST_BITWIDTH-1:0] period_nxt;
    logic                      burst_done_q;

    logic                      clk_en;
    logic                      wrap;
    logic                      burst_last;
    logic                      start;
    logic [P:0]                phase_sum;

    assign clk_en     = (state == ST_RUN) && (psc_cnt == psc_sh);
    assign phase_sum  = {1'b0, phase} + {1'b0, inc_sh};
    assign wrap       = clk_en && phase_sum[P];
    assign period_nxt = period_cnt + BURST_BITWIDTH'(1);
    assign burst_last = wrap && burst_sh && (period_nxt == burstCount_i);
    assign start      = enable_i && (!burstMode_i || (trigger_i && (burstCount_i != '0)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= ST_IDLE;
            psc_cnt      <= '0;
            psc_sh       <= '0;
            phase        <= '0;
            inc_sh       <= '0;
            mode_sh      <= '0;
            duty_sh      <= '0;
            burst_sh     <= 1'b0;
            period_cnt   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= (state == ST_RUN) && enable_i && burst_last;
            case (state)
                ST_IDLE: begin
                    phase      <= '0;
                    psc_cnt    <= '0;
                    period_cnt <= '0;
                    psc_sh     <= prescaler_i;
                    inc_sh     <= phaseInc_i;
                    mode_sh    <= mode_i;
                    duty_sh    <= duty_i;
                    burst_sh   <= burstMode_i;
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state      <= ST_IDLE;
                        phase      <= '0;
                        psc_cnt    <= '0;
                        period_cnt <= '0;
                    end else begin
                        psc_cnt <= clk_en ? '0 : psc_cnt + PSC_BITWIDTH'(1);
                        if (clk_en) begin
                            phase <= phase_sum[P-1:0];
                        end
                        // A new period starts here, so the new config applies to it in full
                        if (wrap) begin
                            psc_sh     <= prescaler_i;
                            inc_sh     <= phaseInc_i;
                            mode_sh    <= mode_i;
                            duty_sh    <= duty_i;
                            period_cnt <= period_nxt;
                            if (burst_last) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [B-1:0] p;
    logic [B-1:0] tri_t;
    logic [B-1:0] wave;

    assign p = phase[P-1:P-B];

    always_comb begin
        wave  = '0;
        tri_t = p[B-1] ? {~p[B-2:0], 1'b0} : {p[B-2:0], 1'b0};
        case (mode_sh)
            MODE_CONST:  wave = POS_FULL;
            MODE_SQUARE: wave = (p < duty_sh) ? POS_FULL : NEG_FULL;
            MODE_TRI:    wave = {~tri_t[B-1], tri_t[B-2:0]};
            MODE_SAW:    wave = {~p[B-1], p[B-2:0]};
            default:     wave = '0;
        endcase
        if (state != ST_RUN) begin
            wave = '0;
        end
    end

    // The final wrap of a burst lands in IDLE, so it produces no sample
    logic                        en_q;
    logic [B-1:0]                s_q;
    logic [OUT_STROBE_DELAY+1:0] vld_sr;
    logic [B-1:0]                out_q;

    logic signed [2*B-1:0] s_ext;
    logic signed [2*B-1:0] amp_ext;
    logic signed [2*B-1:0] prod;
    logic signed [B:0]     scaled;
    logic signed [B+1:0]   sum;
    logic [B-1:0]          sat;
    logic [B-1:0]          out_d;

    assign s_ext   = {{B{s_q[B-1]}}, s_q};
    assign amp_ext = {{B{1'b0}}, amplitude_i};
    assign prod    = s_ext * amp_ext;
    assign scaled  = prod[2*B-1:B-1];
    assign sum     = {scaled[B], scaled} + {{2{offset_i[B-1]}}, offset_i};

    always_comb begin
        sat = sum[B-1:0];
        if (!((&sum[B+1:B-1]) || !(|sum[B+1:B-1]))) begin
            sat = sum[B+1] ? SAT_MIN : POS_FULL;
        end
        out_d = radix_i ? {~sat[B-1], sat[B-2:0]} : sat;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q   <= 1'b0;
            s_q    <= '0;
            vld_sr <= '0;
            out_q  <= '0;
        end else begin
            en_q   <= clk_en && enable_i && !burst_last;
            s_q    <= wave;
            vld_sr <= {vld_sr[OUT_STROBE_DELAY:0], en_q};
            out_q  <= out_d;
        end
    end

    assign out_o           = out_q;
    assign outValid_STRB_o = vld_sr[OUT_STROBE_DELAY+1];
    assign busy_o          = (state == ST_RUN);
    assign burstDone_o     = burst_done_q;

endmodule

// File: tb/tb_fg_burst_waveform_generator.sv
// Scoreboard bench for fg_burst_waveform_generator: expected samples are queued
// when a run is configured and compared on every output strobe.
module tb_fg_burst_waveform_generator;

    localparam int B   = 8;
    localparam int P   = 16;
    localparam int PSC = 9;
    localparam int BW  = 8;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          enable_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic          burstMode_i = 1'b0;
    logic          trigger_i = 1'b0;
    logic [BW-1:0] burstCount_i = '0;
    logic [PSC-1:0] prescaler_i = '0;
    logic [P-1:0]  phaseInc_i = '0;
    logic [B-1:0]  duty_i = '0;
    logic [B-1:0]  amplitude_i = '0;
    logic [B-1:0]  offset_i = '0;
    logic          radix_i = 1'b0;
    logic [B-1:0]  out_o;
    logic          outValid_STRB_o;
    logic          busy_o;
    logic          burstDone_o;

    fg_burst_waveform_generator #(
        .BITWIDTH(B), .PHASE_BITWIDTH(P), .PSC_BITWIDTH(PSC),
        .BURST_BITWIDTH(BW), .OUT_STROBE_DELAY(0)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .mode_i(mode_i),
        .burstMode_i(burstMode_i), .trigger_i(trigger_i), .burstCount_i(burstCount_i),
        .prescaler_i(prescaler_i), .phaseInc_i(phaseInc_i), .duty_i(duty_i),
        .amplitude_i(amplitude_i), .offset_i(offset_i), .radix_i(radix_i),
        .out_o(out_o), .outValid_STRB_o(outValid_STRB_o), .busy_o(busy_o),
        .burstDone_o(burstDone_o)
    );

    always #5 clk_i = ~clk_i;

    int    n_tests = 0;
    int    n_fail = 0;
    int    sb_q[$];
    bit    sb_active = 1'b0;
    string cur_tag = "none";
    int    sb_gap = 0;
    int    cyc = 0;
    int    last_stb = -1;

    always @(posedge clk_i) cyc++;

    task automatic chk_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_out(input int mode, input int p, input int duty, input int amp,
                                   input int off, input int radix, input bit idle);
        int s, t, sc, sm;
        s = 0;
        if (!idle) begin
            case (mode)
                0: s = 127;
                1: s = (p < duty) ? 127 : -127;
                2: begin
                    t = (p < 128) ? 2 * p : 2 * (255 - p);
                    s = t - 128;
                end
                default: s = p - 128;
            endcase
        end
        sc = (s * amp) >>> 7;
        sm = sc + off;
        if (sm > 127) sm = 127;
        if (sm < -128) sm = -128;
        return radix ? sm + 128 : (sm & 255);
    endfunction

    function automatic int phase_p(input int k, input int inc);
        return ((k * inc) % 65536) >> (P - B);
    endfunction

    always @(negedge clk_i) begin
        if (sb_active && outValid_STRB_o) begin
            int e;
            if (sb_gap != 0 && last_stb >= 0) chk_val({cur_tag, "_gap"}, cyc - last_stb, sb_gap);
            last_stb = cyc;
            if (sb_q.size() == 0) begin
                chk_val({cur_tag, "_extra_strobe"}, 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk_val(cur_tag, int'(out_o), e);
            end
        end
    end

    task automatic set_cfg(input int mode, input int inc, input int psc, input int duty,
                           input int amp, input int off, input int radix);
        mode_i      = 2'(mode);
        phaseInc_i  = 16'(inc);
        prescaler_i = 9'(psc);
        duty_i      = 8'(duty);
        amplitude_i = 8'(amp);
        offset_i    = 8'(off);
        radix_i     = 1'(radix);
    endtask

    task automatic arm(input string tag, input int gap);
        cur_tag   = tag;
        sb_gap    = gap;
        last_stb  = -1;
        sb_active = 1'b1;
        enable_i  = 1'b1;
    endtask

    task automatic drain_and_stop(input string tag, input int budget);
        int c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk_i);
            c++;
        end
        chk_val({tag, "_drained"}, sb_q.size(), 0);
        sb_active = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic run_cont(input string tag, input int mode, input int inc, input int psc,
                            input int duty, input int amp, input int off, input int radix,
                            input int n, input int gap);
        @(negedge clk_i);
        burstMode_i = 1'b0;
        set_cfg(mode, inc, psc, duty, amp, off, radix);
        for (int k = 1; k <= n; k++)
            sb_q.push_back(exp_out(mode, phase_p(k, inc), duty, amp, off, radix, 1'b0));
        arm(tag, gap);
        drain_and_stop(tag, n * (psc + 1) + 20);
        chk_val({tag, "_idle_out"}, int'(out_o), exp_out(mode, 0, duty, amp, off, radix, 1'b1));
        chk_val({tag, "_idle_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_after, busy_seen;
        bit prev_busy;

        repeat (3) @(negedge clk_i);
        chk_val("rst_out", int'(out_o), 0);
        chk_val("rst_strobe", int'(outValid_STRB_o), 0);
        chk_val("rst_busy", int'(busy_o), 0);
        chk_val("rst_done", int'(burstDone_o), 0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        run_cont("saw", 3, 'h1000, 0, 0, 128, 0, 0, 32, 1);
        run_cont("square", 1, 'h2000, 3, 64, 128, 0, 0, 16, 4);
        run_cont("tri", 2, 'h0800, 1, 0, 64, -10, 1, 40, 2);
        run_cont("sat_hi", 0, 'h1000, 0, 0, 255, 100, 0, 4, 1);
        run_cont("sat_hi_u", 0, 'h1000, 0, 0, 255, 100, 1, 4, 1);
        run_cont("sat_lo", 0, 'h1000, 0, 0, 0, -128, 0, 4, 1);
        run_cont("sat_lo_u", 0, 'h1000, 0, 0, 0, -128, 1, 4, 1);

        // phase increment changed mid-period: old step until the wrap
        @(negedge clk_i);
        set_cfg(3, 'h1000, 0, 0, 128, 0, 0);
        for (int k = 1; k <= 16; k++) sb_q.push_back(exp_out(3, phase_p(k, 'h1000), 0, 128, 0, 0, 1'b0));
        for (int k = 1; k <= 8; k++) sb_q.push_back(exp_out(3, phase_p(k, 'h2000), 0, 128, 0, 0, 1'b0));
        arm("shadow_inc", 1);
        repeat (5) @(negedge clk_i);
        phaseInc_i = 16'h2000;
        drain_and_stop("shadow_inc", 60);

        // mode changed mid-period: sawtooth until the wrap, then triangle
        @(negedge clk_i);
        set_cfg(3, 'h2000, 0, 0, 128, 0, 0);
        for (int k = 1; k <= 7; k++) sb_q.push_back(exp_out(3, phase_p(k, 'h2000), 0, 128, 0, 0, 1'b0));
        for (int k = 0; k <= 7; k++) sb_q.push_back(exp_out(2, phase_p(k, 'h2000), 0, 128, 0, 0, 1'b0));
        arm("shadow_mode", 1);
        repeat (3) @(negedge clk_i);
        mode_i = 2'b10;
        drain_and_stop("shadow_mode", 60);

        // triggered burst of 3 periods of 4 samples
        @(negedge clk_i);
        set_cfg(3, 'h4000, 0, 0, 128, 20, 0);
        burstMode_i = 1'b1;
        burstCount_i = 8'd3;
        enable_i = 1'b1;
        trigger_i = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_after = 0; prev_busy = 1'b0;
        @(negedge clk_i);
        trigger_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) busy_cnt++;
            if (burstDone_o) begin
                done_cnt++;
                if (prev_busy && !busy_o) done_after++;
            end
            prev_busy = busy_o;
            @(negedge clk_i);
        end
        chk_val("burst_busy_cycles", busy_cnt, 12);
        chk_val("burst_done_pulses", done_cnt, 1);
        chk_val("burst_done_timing", done_after, 1);
        chk_val("burst_end_out", int'(out_o), 20);

        // burstCount=0 ignores the trigger
        burstCount_i = 8'd0;
        trigger_i = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (busy_o) busy_seen++;
        end
        trigger_i = 1'b0;
        chk_val("burst_zero_idle", busy_seen, 0);

        // abort mid-burst
        burstCount_i = 8'd5;
        phaseInc_i = 16'h1000;
        trigger_i = 1'b1;
        @(negedge clk_i);
        trigger_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk_val("abort_busy_before", int'(busy_o), 1);
        enable_i = 1'b0;
        @(negedge clk_i);
        chk_val("abort_busy_after", int'(busy_o), 0);
        done_cnt = int'(burstDone_o);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (burstDone_o) done_cnt++;
        end
        chk_val("abort_no_done", done_cnt, 0);

        // asynchronous reset during a run
        burstMode_i = 1'b0;
        set_cfg(0, 'h1000, 0, 0, 128, 0, 0);
        enable_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk_val("prerst_out", int'(out_o), 127);
        chk_val("prerst_strobe", int'(outValid_STRB_o), 1);
        chk_val("prerst_busy", int'(busy_o), 1);
        #2 rstn_i = 1'b0;
        #1;
        chk_val("async_rst_out", int'(out_o), 0);
        chk_val("async_rst_strobe", int'(outValid_STRB_o), 0);
        chk_val("async_rst_busy", int'(busy_o), 0);
        chk_val("async_rst_done", int'(burstDone_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
